bus_cycle_monitor: RTL and testbench

//  CPU-side terminator for the memory-region dtack/berr protocol. Region controllers (RAM, ROM, IO, unmapped)

---
 rtl/bus_cycle_monitor_if.sv | 34 +++
 rtl/bus_cycle_monitor.sv | 168 ++++++++++++++++
 tb/tb_bus_cycle_monitor.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_cycle_monitor_if.sv
`timescale 1ns/1ps
// bus_cycle_monitor_if
//   CPU bus cycle signals as seen by the cycle monitor.
//   master : CPU and region controllers. They drive as_n/addr/dtack/berr and
//            receive the terminated cpu_dtack_n/cpu_berr_n.
//   slave  : bus_cycle_monitor. It samples the cycle and region response and
//            drives cpu_dtack_n/cpu_berr_n.
//   Signals:
//     as_n        address strobe, active-low
//     addr        CPU address, valid while as_n low
//     dtack       shared region ack, active-low (pulled up when idle)
//     berr        shared region bus error, active-high (pulled down when idle)
//     cpu_dtack_n registered DTACK to the CPU, active-low
//     cpu_berr_n  registered BERR to the CPU, active-low
interface bus_cycle_monitor_if #(
  parameter int ADDR_WIDTH = 24
);
  logic                  as_n;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  dtack;
  logic                  berr;
  logic                  cpu_dtack_n;
  logic                  cpu_berr_n;

  modport master (
    output as_n, addr, dtack, berr,
    input  cpu_dtack_n, cpu_berr_n
  );

  modport slave (
    input  as_n, addr, dtack, berr,
    output cpu_dtack_n, cpu_berr_n
  );
endinterface

// File: rtl/bus_cycle_monitor.sv
`timescale 1ns/1ps
// bus_cycle_monitor
//   CPU-side terminator for the dtack/berr region protocol. Each CPU cycle
//   (as_n low) waits for a region response; dtack becomes cpu_dtack_n, berr
//   becomes cpu_berr_n, and silence for TIMEOUT clocks becomes a forced bus
//   error. Every bus error is logged (address, cause, sticky flag, count).
//   Ports:
//     clk           system clock, rising edge
//     reset         asynchronous active-high reset
//     bus           bus_cycle_monitor_if.slave (as_n, addr, dtack, berr in;
//                   cpu_dtack_n, cpu_berr_n out, both registered)
//     fault_clr     one-clock pulse clearing fault_valid
//     fault_valid   sticky: a bus error occurred since the last clear
//     fault_timeout 1 = last fault was a timeout, 0 = region berr
//     fault_addr    address of the most recent faulting cycle
//     fault_count   faults since reset, saturating at all-ones
module bus_cycle_monitor #(
  parameter int TIMEOUT     = 64,
  parameter int ADDR_WIDTH  = 24,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  bus_cycle_monitor_if.slave     bus,
  input  logic                   fault_clr,
  output logic                   fault_valid,
  output logic                   fault_timeout,
  output logic [ADDR_WIDTH-1:0]  fault_addr,
  output logic [COUNT_WIDTH-1:0] fault_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    ERR  = 2'd3
  } state_e;

  // Wait counter is sized for the largest legal TIMEOUT (2**16-1).
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  state_e                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   cpu_dtack_n_q, cpu_dtack_n_d;
  logic                   cpu_berr_n_q, cpu_berr_n_d;
  logic                   fault_valid_q, fault_valid_d;
  logic                   fault_timeout_q, fault_timeout_d;
  logic [ADDR_WIDTH-1:0]  fault_addr_q, fault_addr_d;
  logic [COUNT_WIDTH-1:0] fault_count_q, fault_count_d;

  logic dtack_on_s;
  logic berr_on_s;
  logic fault_s;
  logic fault_to_s;

  // A floating (z) or unknown shared line must never count as a response,
  // hence the exact-value compares.
  assign dtack_on_s = (bus.dtack === 1'b0);
  assign berr_on_s  = (bus.berr === 1'b1);

  // Cycle state machine: next state, wait counter and fault event.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fault_s    = 1'b0;
    fault_to_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.as_n == 1'b0) begin
          state_d = WAIT;
          cnt_d   = 16'd0;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // Abort beats any response; berr beats a simultaneous dtack; a real
        // response on the final count beats the timeout.
        if (bus.as_n == 1'b1) begin
          state_d = IDLE;
        end else if (berr_on_s) begin
          state_d = ERR;
          fault_s = 1'b1;
        end else if (dtack_on_s) begin
          state_d = ACK;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ERR;
          fault_s    = 1'b1;
          fault_to_s = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ACK, ERR: begin
        // Response lines are ignored here; only the end of the cycle matters.
        if (bus.as_n == 1'b1) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // CPU outputs follow the state being entered, so they change on the same
  // edge as the state and are mutually exclusive by construction.
  always_comb begin
    cpu_dtack_n_d = (state_d == ACK) ? 1'b0 : 1'b1;
    cpu_berr_n_d  = (state_d == ERR) ? 1'b0 : 1'b1;
  end

  // Fault log: a new fault wins over a coincident fault_clr.
  always_comb begin
    fault_valid_d   = fault_valid_q;
    fault_timeout_d = fault_timeout_q;
    fault_addr_d    = fault_addr_q;
    fault_count_d   = fault_count_q;
    if (fault_s) begin
      fault_valid_d   = 1'b1;
      fault_timeout_d = fault_to_s;
      fault_addr_d    = bus.addr;
      if (fault_count_q != COUNT_MAX) begin
        fault_count_d = fault_count_q + COUNT_WIDTH'(1);
      end else begin
        fault_count_d = fault_count_q;
      end
    end else if (fault_clr) begin
      fault_valid_d = 1'b0;
    end else begin
      fault_valid_d = fault_valid_q;
    end
  end

  // All state; async reset drops any cycle in progress and releases outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= 16'd0;
      cpu_dtack_n_q   <= 1'b1;
      cpu_berr_n_q    <= 1'b1;
      fault_valid_q   <= 1'b0;
      fault_timeout_q <= 1'b0;
      fault_addr_q    <= {ADDR_WIDTH{1'b0}};
      fault_count_q   <= {COUNT_WIDTH{1'b0}};
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      cpu_dtack_n_q   <= cpu_dtack_n_d;
      cpu_berr_n_q    <= cpu_berr_n_d;
      fault_valid_q   <= fault_valid_d;
      fault_timeout_q <= fault_timeout_d;
      fault_addr_q    <= fault_addr_d;
      fault_count_q   <= fault_count_d;
    end
  end

  assign bus.cpu_dtack_n = cpu_dtack_n_q;
  assign bus.cpu_berr_n  = cpu_berr_n_q;
  assign fault_valid     = fault_valid_q;
  assign fault_timeout   = fault_timeout_q;
  assign fault_addr      = fault_addr_q;
  assign fault_count     = fault_count_q;

endmodule

// File: tb/tb_bus_cycle_monitor.sv
`timescale 1ns/1ps
// Scoreboard bench for bus_cycle_monitor with TIMEOUT=8 and COUNT_WIDTH=2.
// Stimulus issues CPU cycles and pushes the expected CPU response (kind, edge
// number, fault log contents) into a queue; a monitor pops on every falling
// cpu_dtack_n/cpu_berr_n and compares.
module tb_bus_cycle_monitor;
  localparam int TIMEOUT = 8;
  localparam int AW      = 24;
  localparam int CW      = 2;
  localparam int CMAX    = 3;

  // Transaction kinds
  localparam int K_ACK = 0, K_BERR = 1, K_BOTH = 2, K_TMO = 3, K_ABORT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          fault_clr;
  logic          fault_valid;
  logic          fault_timeout;
  logic [AW-1:0] fault_addr;
  logic [CW-1:0] fault_count;

  bus_cycle_monitor_if #(.ADDR_WIDTH(AW)) bus ();

  bus_cycle_monitor #(.TIMEOUT(TIMEOUT), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus), .fault_clr(fault_clr),
    .fault_valid(fault_valid), .fault_timeout(fault_timeout),
    .fault_addr(fault_addr), .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            kind;     // 1 = dtack response, 2 = berr response
    int            edge_no;  // posedge number on which the output falls
    bit            valid;
    bit            tmo;
    logic [AW-1:0] addr;
    int            count;
  } exp_t;

  exp_t          q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;

  // Reference fault log
  bit            m_valid;
  bit            m_tmo;
  logic [AW-1:0] m_addr;
  int            m_count;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_tmo = 1'b0; m_addr = '0; m_count = 0;
  endtask

  task automatic model_fault(input bit tmo, input logic [AW-1:0] a);
    m_valid = 1'b1;
    m_tmo   = tmo;
    m_addr  = a;
    m_count = (m_count < CMAX) ? m_count + 1 : CMAX;
  endtask

  task automatic push(input int kind, input int edge_no);
    exp_t e;
    e.kind = kind; e.edge_no = edge_no; e.valid = m_valid; e.tmo = m_tmo;
    e.addr = m_addr; e.count = m_count;
    q.push_back(e);
  endtask

  // Monitor: compare on each newly asserted CPU response
  initial begin
    bit   p_dt, p_be;
    exp_t e;
    p_dt = 1'b1; p_be = 1'b1;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) begin
        p_dt = 1'b1; p_be = 1'b1;
      end else begin
        if ((p_dt && bus.cpu_dtack_n === 1'b0) || (p_be && bus.cpu_berr_n === 1'b0)) begin
          if (q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_response: got dtack_n=%b berr_n=%b expected none (cycle %0d)",
                     bus.cpu_dtack_n, bus.cpu_berr_n, cyc);
          end else begin
            e = q.pop_front();
            chk("resp_lines", {30'd0, bus.cpu_dtack_n, bus.cpu_berr_n},
                (e.kind == 1) ? 32'd1 : 32'd2);
            chk("resp_edge", cyc, e.edge_no);
            chk("fault_valid", {31'd0, fault_valid}, {31'd0, e.valid});
            chk("fault_timeout", {31'd0, fault_timeout}, {31'd0, e.tmo});
            chk("fault_addr", {8'd0, fault_addr}, {8'd0, e.addr});
            chk("fault_count", {30'd0, fault_count}, e.count);
          end
        end
        p_dt = bus.cpu_dtack_n;
        p_be = bus.cpu_berr_n;
      end
    end
  end

  // One CPU cycle. k = clocks after WAIT entry before the response (or abort).
  task automatic run_txn(input int kind, input int k, input logic [AW-1:0] a,
                         input bit clr_with, input bit clr_gap);
    int start;
    start     = cyc;
    bus.as_n  = 1'b0;
    bus.addr  = a;
    tick();                       // as_n sampled: cycle begins
    fault_clr = 1'b0;
    if (kind == K_TMO) begin
      while (cyc < start + TIMEOUT) tick();
      if (clr_with) fault_clr = 1'b1;
      model_fault(1'b1, a);
      push(2, start + TIMEOUT + 1);
    end else if (kind == K_ABORT) begin
      repeat (k) tick();
    end else begin
      repeat (k) tick();
      if (kind == K_ACK || kind == K_BOTH) bus.dtack = 1'b0;
      if (kind == K_BERR || kind == K_BOTH) bus.berr = 1'b1;
      if (clr_with) fault_clr = 1'b1;
      if (kind == K_ACK) begin
        if (clr_with) m_valid = 1'b0;
        push(1, start + 2 + k);
      end else begin
        model_fault(1'b0, a);
        push(2, start + 2 + k);
      end
    end
    if (kind != K_ABORT) begin
      tick();                     // response edge
      fault_clr = 1'b0;
      // Response lines wander while the CPU holds the cycle; must be ignored.
      repeat ($urandom_range(0, 2)) begin
        bus.dtack = 1'($urandom_range(0, 1));
        bus.berr  = 1'($urandom_range(0, 1));
        tick();
      end
    end
    bus.as_n  = 1'b1;
    bus.dtack = 1'b1;
    bus.berr  = 1'b0;
    if (clr_gap) begin
      fault_clr = 1'b1;
      m_valid   = 1'b0;
    end
    tick();                       // single high sample ends the cycle
    fault_clr = 1'b0;
    chk("gap_dtack_n", {31'd0, bus.cpu_dtack_n}, 32'd1);
    chk("gap_berr_n", {31'd0, bus.cpu_berr_n}, 32'd1);
    chk("gap_fault_valid", {31'd0, fault_valid}, {31'd0, m_valid});
    chk("gap_fault_count", {30'd0, fault_count}, m_count);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    fault_clr = 1'b0;
    bus.as_n  = 1'b1;
    bus.addr  = '0;
    bus.dtack = 1'b1;
    bus.berr  = 1'b0;
    model_reset();
    #23;
    chk("rst_dtack_n", {31'd0, bus.cpu_dtack_n}, 32'd1);
    chk("rst_berr_n", {31'd0, bus.cpu_berr_n}, 32'd1);
    chk("rst_fault_valid", {31'd0, fault_valid}, 32'd0);
    chk("rst_fault_timeout", {31'd0, fault_timeout}, 32'd0);
    chk("rst_fault_addr", {8'd0, fault_addr}, 32'd0);
    chk("rst_fault_count", {30'd0, fault_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Directed cases
    run_txn(K_ACK,   2, 24'h000010, 1'b0, 1'b0);
    run_txn(K_BERR,  1, 24'h000100, 1'b0, 1'b0);
    run_txn(K_TMO,   0, 24'hFF0000, 1'b0, 1'b0);
    run_txn(K_BOTH,  0, 24'h123456, 1'b0, 1'b0);
    run_txn(K_ABORT, 3, 24'h0000AA, 1'b0, 1'b0);
    run_txn(K_BERR,  TIMEOUT - 1, 24'h00BEEF, 1'b0, 1'b0);  // response on final count
    run_txn(K_ACK,   TIMEOUT - 1, 24'h00CAFE, 1'b0, 1'b0);
    run_txn(K_BERR,  2, 24'h0A0A0A, 1'b1, 1'b0);            // clr coincident with fault
    run_txn(K_ACK,   1, 24'h000020, 1'b0, 1'b1);            // clr alone
    run_txn(K_TMO,   0, 24'h00F00F, 1'b1, 1'b0);            // clr coincident with timeout

    // Random cycles
    for (int i = 0; i < 60; i++) begin
      run_txn($urandom_range(0, 4), $urandom_range(0, TIMEOUT - 1), AW'($urandom),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    // Reset while in ERR
    bus.as_n = 1'b0;
    bus.addr = 24'h00ABCD;
    tick();
    bus.berr = 1'b1;
    model_fault(1'b0, 24'h00ABCD);
    push(2, cyc + 1);
    tick();
    bus.berr = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_berr_n", {31'd0, bus.cpu_berr_n}, 32'd1);
    chk("midrst_dtack_n", {31'd0, bus.cpu_dtack_n}, 32'd1);
    chk("midrst_fault_valid", {31'd0, fault_valid}, 32'd0);
    chk("midrst_fault_timeout", {31'd0, fault_timeout}, 32'd0);
    chk("midrst_fault_addr", {8'd0, fault_addr}, 32'd0);
    chk("midrst_fault_count", {30'd0, fault_count}, 32'd0);
    bus.as_n = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    tick();
    run_txn(K_BERR, 0, 24'h000777, 1'b0, 1'b0);

    repeat (3) tick();
    chk("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
